// File: rtl/alu_operand_stage.sv
// alu_operand_stage: decode-to-execute stage feeding the ALU lhs/rhs/func inputs.
//
// Resolves each source operand at acceptance time. x0 always reads zero. When
// FORWARDING_EN is defined, EX/MEM and WB results are forwarded: EX/MEM wins over
// WB, and WB wins over the register-file data. Only then is the operand select
// applied (rs1/PC, rs2/imm). The resolved set is held in a two-entry skid buffer:
// MAIN drives out_*, and SKID absorbs one set when the ALU stalls.
//
// Build option:
//   FORWARDING_EN  defined   -> forwarding network active
//                  undefined -> exm_* / wb_* ignored, operands from in_rsN_data only
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   flush                      synchronous kill of MAIN and SKID
//   in_valid / in_ready        upstream handshake (in_ready is !skid_valid, from state)
//   in_rs1_addr/data, in_rs2_addr/data, in_pc, in_imm, in_func, in_lhs_sel, in_rhs_sel
//   exm_wr_en/addr/data        EX/MEM write-back bus
//   wb_wr_en/addr/data         WB write-back bus
//   out_valid / out_ready      ALU-side handshake
//   out_lhs, out_rhs, out_func operand set toward the ALU
module alu_operand_stage #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned FUNC_W = 4,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_rs1_addr,
  input  logic [REG_AW-1:0] in_rs2_addr,
  input  logic [XLEN-1:0]   in_rs1_data,
  input  logic [XLEN-1:0]   in_rs2_data,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [FUNC_W-1:0] in_func,
  input  logic              in_lhs_sel,
  input  logic              in_rhs_sel,
  input  logic              exm_wr_en,
  input  logic [REG_AW-1:0] exm_wr_addr,
  input  logic [XLEN-1:0]   exm_wr_data,
  input  logic              wb_wr_en,
  input  logic [REG_AW-1:0] wb_wr_addr,
  input  logic [XLEN-1:0]   wb_wr_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_lhs,
  output logic [XLEN-1:0]   out_rhs,
  output logic [FUNC_W-1:0] out_func
);

  localparam int unsigned EntryW = 2 * XLEN + FUNC_W;

  localparam logic [1:0] StEmpty = 2'd0;
  localparam logic [1:0] StFull  = 2'd1;
  localparam logic [1:0] StSkid  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [EntryW-1:0] main_q, skid_q;
  logic [EntryW-1:0] new_entry;
  logic [XLEN-1:0]   rs1_val, rs2_val;
  logic              accept, pop;
  logic              main_load, main_from_skid, skid_load;

  // Operand resolution
`ifdef FORWARDING_EN
  logic exm_hit1, exm_hit2, wb_hit1, wb_hit2;
  assign exm_hit1 = exm_wr_en && (exm_wr_addr == in_rs1_addr);
  assign exm_hit2 = exm_wr_en && (exm_wr_addr == in_rs2_addr);
  assign wb_hit1  = wb_wr_en && (wb_wr_addr == in_rs1_addr);
  assign wb_hit2  = wb_wr_en && (wb_wr_addr == in_rs2_addr);
`else
  logic fwd_unused;
  assign fwd_unused = ^{exm_wr_en, exm_wr_addr, exm_wr_data, wb_wr_en, wb_wr_addr, wb_wr_data};
`endif

  always_comb begin
    rs1_val = in_rs1_data;
    rs2_val = in_rs2_data;
`ifdef FORWARDING_EN
    // Later assignments take priority: EX/MEM overrides WB.
    if (wb_hit1)  rs1_val = wb_wr_data;
    if (wb_hit2)  rs2_val = wb_wr_data;
    if (exm_hit1) rs1_val = exm_wr_data;
    if (exm_hit2) rs2_val = exm_wr_data;
`endif
    // x0 is hard-wired zero and overrides any forwarded value.
    if (in_rs1_addr == '0) rs1_val = '0;
    if (in_rs2_addr == '0) rs2_val = '0;
  end

  assign new_entry = {(in_lhs_sel ? in_pc : rs1_val), (in_rhs_sel ? in_imm : rs2_val), in_func};

  // Handshakes
  assign in_ready  = (state_q != StSkid);
  assign out_valid = (state_q != StEmpty);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    case (state_q)
      StEmpty: begin
        if (accept) begin
          state_d   = StFull;
          main_load = 1'b1;
        end
      end
      StFull: begin
        if (accept && pop) begin
          main_load = 1'b1;
        end else if (accept) begin
          state_d   = StSkid;
          skid_load = 1'b1;
        end else if (pop) begin
          state_d = StEmpty;
        end
      end
      StSkid: begin
        if (pop) begin
          state_d        = StFull;
          main_load      = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: state_d = StEmpty;
    endcase
    // Flush wins over any concurrent acceptance; a concurrent pop has already happened.
    if (flush) begin
      state_d   = StEmpty;
      main_load = 1'b0;
      skid_load = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      if (main_load) main_q <= main_from_skid ? skid_q : new_entry;
      if (skid_load) skid_q <= new_entry;
    end
  end

  assign out_lhs  = main_q[EntryW-1 -: XLEN];
  assign out_rhs  = main_q[FUNC_W +: XLEN];
  assign out_func = main_q[FUNC_W-1:0];

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed scenarios followed by random traffic. All
// of it is checked against a queue-based reference model.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_rs1_addr = '0, in_rs2_addr = '0;
  logic [31:0] in_rs1_data = '0, in_rs2_data = '0, in_pc = '0, in_imm = '0;
  logic [3:0]  in_func = '0;
  logic        in_lhs_sel = 1'b0, in_rhs_sel = 1'b0;
  logic        exm_wr_en = 1'b0, wb_wr_en = 1'b0;
  logic [4:0]  exm_wr_addr = '0, wb_wr_addr = '0;
  logic [31:0] exm_wr_data = '0, wb_wr_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_lhs, out_rhs;
  logic [3:0]  out_func;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] lhs;
    logic [31:0] rhs;
    logic [3:0]  func;
  } set_t;

  set_t model_q[$];

  alu_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_pc(in_pc), .in_imm(in_imm), .in_func(in_func),
    .in_lhs_sel(in_lhs_sel), .in_rhs_sel(in_rhs_sel),
    .exm_wr_en(exm_wr_en), .exm_wr_addr(exm_wr_addr), .exm_wr_data(exm_wr_data),
    .wb_wr_en(wb_wr_en), .wb_wr_addr(wb_wr_addr), .wb_wr_data(wb_wr_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_lhs(out_lhs), .out_rhs(out_rhs), .out_func(out_func)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Value of one source register as the execute stage should see it.
  function automatic logic [31:0] source(input logic [4:0] addr, input logic [31:0] rf);
    if (addr == 0) return 32'd0;
`ifdef FORWARDING_EN
    if (exm_wr_en && exm_wr_addr == addr) return exm_wr_data;
    if (wb_wr_en && wb_wr_addr == addr) return wb_wr_data;
`endif
    return rf;
  endfunction

  task automatic compare();
    check("in_ready", {31'd0, in_ready}, {31'd0, model_q.size() < 2});
    check("out_valid", {31'd0, out_valid}, {31'd0, model_q.size() > 0});
    if (model_q.size() > 0) begin
      check("out_lhs", out_lhs, model_q[0].lhs);
      check("out_rhs", out_rhs, model_q[0].rhs);
      check("out_func", {28'd0, out_func}, {28'd0, model_q[0].func});
    end
  endtask

  // One clock: the model sees the same inputs the DUT samples at the edge.
  task automatic tick();
    set_t s;
    bit acc, pop;
    acc = in_valid && (model_q.size() < 2);
    pop = out_ready && (model_q.size() > 0);
    s.lhs  = in_lhs_sel ? in_pc : source(in_rs1_addr, in_rs1_data);
    s.rhs  = in_rhs_sel ? in_imm : source(in_rs2_addr, in_rs2_data);
    s.func = in_func;
    @(posedge clk);
    #1;
    if (pop) void'(model_q.pop_front());
    if (flush) model_q.delete();
    else if (acc) model_q.push_back(s);
    compare();
  endtask

  task automatic set_in(input logic [4:0] a1, input logic [31:0] d1,
                        input logic [4:0] a2, input logic [31:0] d2, input logic [3:0] f);
    in_rs1_addr = a1; in_rs1_data = d1;
    in_rs2_addr = a2; in_rs2_data = d2;
    in_func = f;
  endtask

  initial begin
    // Reset
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_out_lhs", out_lhs, 32'd0);
    check("reset_out_rhs", out_rhs, 32'd0);
    check("reset_out_func", {28'd0, out_func}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_in_ready", {31'd0, in_ready}, 32'd1);

    // 1: basic transfer
    set_in(5'd1, 32'd5, 5'd2, 32'd7, 4'd0);
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    check("t1_valid", {31'd0, out_valid}, 32'd1);
    check("t1_lhs", out_lhs, 32'd5);
    check("t1_rhs", out_rhs, 32'd7);
    in_valid = 1'b0;
    tick();

    // 2: back-pressure with A, B, C
    out_ready = 1'b0; in_valid = 1'b1;
    set_in(5'd4, 32'hA, 5'd5, 32'hA0, 4'd1); tick();
    set_in(5'd4, 32'hB, 5'd5, 32'hB0, 4'd2); tick();
    set_in(5'd4, 32'hC, 5'd5, 32'hC0, 4'd3); tick();
    check("t2_hold_A", out_lhs, 32'hA);
    check("t2_in_ready_low", {31'd0, in_ready}, 32'd0);
    tick();
    check("t2_still_A", out_lhs, 32'hA);
    out_ready = 1'b1;
    tick();
    check("t2_B", out_lhs, 32'hB);
    tick();
    check("t2_C", out_lhs, 32'hC);
    check("t2_C_func", {28'd0, out_func}, 32'd3);
    in_valid = 1'b0;
    tick();
    check("t2_empty", {31'd0, out_valid}, 32'd0);

    // 3: forwarding priority
    set_in(5'd3, 32'h33, 5'd6, 32'h66, 4'd0);
    exm_wr_en = 1'b1; exm_wr_addr = 5'd3; exm_wr_data = 32'h11;
    wb_wr_en = 1'b1; wb_wr_addr = 5'd3; wb_wr_data = 32'h22;
    in_valid = 1'b1;
    tick();
`ifdef FORWARDING_EN
    check("t3_exm_priority", out_lhs, 32'h11);
`else
    check("t6_no_fwd_exm", out_lhs, 32'h33);
`endif
    exm_wr_en = 1'b0;
    tick();
`ifdef FORWARDING_EN
    check("t3_wb_fwd", out_lhs, 32'h22);
`else
    check("t6_no_fwd_wb", out_lhs, 32'h33);
`endif
    // Held entry must keep its resolved value when the buses change.
    out_ready = 1'b0; in_valid = 1'b0;
    wb_wr_data = 32'h99;
    tick();
    wb_wr_en = 1'b0;

    // 4: x0 never forwarded, imm select
    out_ready = 1'b1; in_valid = 1'b1;
    set_in(5'd7, 32'h1, 5'd0, 32'h1234, 4'd6);
    exm_wr_en = 1'b1; exm_wr_addr = 5'd0; exm_wr_data = 32'hFFFF_FFFF;
    tick();
    check("t4_x0", out_rhs, 32'd0);
    in_rhs_sel = 1'b1; in_imm = 32'hFFFF_FFF0;
    tick();
    check("t4_imm", out_rhs, 32'hFFFF_FFF0);
    in_lhs_sel = 1'b1; in_pc = 32'h0000_1000;
    tick();
    check("t4_pc", out_lhs, 32'h0000_1000);
    in_lhs_sel = 1'b0; in_rhs_sel = 1'b0; exm_wr_en = 1'b0;

    // 5: flush from SKID with a concurrent input
    out_ready = 1'b0;
    set_in(5'd8, 32'h81, 5'd9, 32'h91, 4'd1); tick();
    set_in(5'd8, 32'h82, 5'd9, 32'h92, 4'd2); tick();
    check("t5_skid_full", {31'd0, in_ready}, 32'd0);
    tick();
    set_in(5'd8, 32'h83, 5'd9, 32'h93, 4'd3);
    flush = 1'b1;
    tick();
    check("t5_flush_valid", {31'd0, out_valid}, 32'd0);
    check("t5_flush_ready", {31'd0, in_ready}, 32'd1);
    flush = 1'b0; in_valid = 1'b0;
    tick();
    check("t5_nothing_accepted", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset while entries are held
    in_valid = 1'b1;
    tick(); tick();
    #3;
    rst_n = 1'b0;
    #1;
    model_q.delete();
    check("mid_reset_valid", {31'd0, out_valid}, 32'd0);
    check("mid_reset_lhs", out_lhs, 32'd0);
    check("mid_reset_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid    = 1'($urandom_range(0, 1));
      out_ready   = ($urandom_range(0, 2) != 0);
      flush       = ($urandom_range(0, 24) == 0);
      set_in(5'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 3)), $urandom,
             4'($urandom_range(0, 6)));
      in_pc       = $urandom;
      in_imm      = $urandom;
      in_lhs_sel  = ($urandom_range(0, 3) == 0);
      in_rhs_sel  = ($urandom_range(0, 3) == 0);
      exm_wr_en   = 1'($urandom_range(0, 1));
      exm_wr_addr = 5'($urandom_range(0, 3));
      exm_wr_data = $urandom;
      wb_wr_en    = 1'($urandom_range(0, 1));
      wb_wr_addr  = 5'($urandom_range(0, 3));
      wb_wr_data  = $urandom;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
